// File: rtl/iddr_cal_window.sv
// Passing-window tracker for delay-tap training.
// Fed one pass/fail result per tap in ascending tap order, it tracks the
// current run of consecutive passing taps and keeps the longest run seen.
// Ties keep the earlier run. Usable by any tap-sweep trainer (IDDR, ODDR,
// IDELAY) that presents results one tap at a time.
module iddr_cal_window #(
  parameter int TAP_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,       // forget all runs before a new sweep
  input  logic             update_i,      // one result is presented this cycle
  input  logic             pass_i,        // result for tap_i
  input  logic             last_i,        // tap_i is the final tap of the sweep
  input  logic [TAP_W:0]   tap_i,
  output logic [TAP_W:0]   best_start_o,
  output logic [TAP_W:0]   best_len_o
);

  // One extra bit so a run covering every tap cannot overflow.
  localparam int TW1 = TAP_W + 1;

  logic [TW1-1:0] run_start_q, run_start_d;
  logic [TW1-1:0] run_len_q, run_len_d;
  logic [TW1-1:0] best_start_q, best_start_d;
  logic [TW1-1:0] best_len_q, best_len_d;

  logic [TW1-1:0] ext_start, ext_len;
  logic [TW1-1:0] close_start, close_len;
  logic           close_en;

  // Next-state for the run and best trackers.
  // NOTE: every signal driven in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    ext_start    = (run_len_q == '0) ? tap_i : run_start_q;
    ext_len      = run_len_q + TW1'(1);
    close_start  = run_start_q;
    close_len    = run_len_q;
    close_en     = 1'b0;

    if (clear_i) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (update_i) begin
      if (pass_i) begin
        run_start_d = ext_start;
        if (last_i) begin
          // Sweep ends inside a passing run: close it including this tap.
          close_en    = 1'b1;
          close_start = ext_start;
          close_len   = ext_len;
          run_len_d   = '0;
        end else begin
          run_len_d = ext_len;
        end
      end else begin
        close_en  = 1'b1;
        run_len_d = '0;
      end

      // Strictly longer only, so the first of equal-length runs is kept.
      if (close_en && (close_len > best_len_q)) begin
        best_start_d = close_start;
        best_len_d   = close_len;
      end
    end
  end

  // Tracker state registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/iddr_cal.sv
// Multi-lane generic input DDR capture with per-lane delay-tap training.
// Each lane is captured by a rise/fall register pair re-timed to posedge.
// On cal_start, every lane's external delay tap is swept 0..MAX_TAP against
// a static training pattern; the centre of the widest passing window is
// then loaded, or DEFAULT_TAP if no window reaches MIN_EYE taps.
module iddr_cal #(
  parameter int   WIDTH         = 1,
  parameter int   TAP_W         = 9,
  parameter int   MAX_TAP       = 511,
  parameter int   SETTLE_CYCLES = 8,
  parameter int   SAMPLE_CYCLES = 16,
  parameter int   MIN_EYE       = 4,
  parameter int   DEFAULT_TAP   = 0,
  parameter logic TRAIN_Q1      = 1'b1,
  parameter logic TRAIN_Q2      = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q1,
  output logic [WIDTH-1:0]       q2,
  input  logic                   cal_start,
  output logic                   cal_busy,
  output logic                   cal_done,
  output logic [WIDTH-1:0]       lane_ok,
  output logic [WIDTH*TAP_W-1:0] dly_cnt_value,
  output logic [WIDTH-1:0]       dly_load
);

  localparam int TW1     = TAP_W + 1;
  localparam int LANE_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MAX_CNT = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_UPDATE,
    S_CENTER,
    S_DONE
  } state_e;

  // Capture path
  logic [WIDTH-1:0] rise_q, fall_q, q1_q, q2_q;

  // Training control
  state_e                 state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [TW1-1:0]         tap_q, tap_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   fail_q, fail_d;
  logic [WIDTH-1:0]       lane_ok_q, lane_ok_d;
  logic [WIDTH*TAP_W-1:0] dly_cnt_value_q, dly_cnt_value_d;
  logic [WIDTH-1:0]       dly_load_q, dly_load_d;

  logic                   win_clear, win_update;
  logic [TW1-1:0]         best_start, best_len, center_tap;

  // Rising-edge sample and re-timing of both samples onto posedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      q1_q   <= '0;
      q2_q   <= '0;
    end else begin
      rise_q <= d;
      q1_q   <= rise_q;
      q2_q   <= fall_q;
    end
  end

  // Falling-edge sample of the same clk period as rise_q.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) fall_q <= '0;
    else     fall_q <= d;
  end

  iddr_cal_window #(
    .TAP_W (TAP_W)
  ) u_window (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (win_clear),
    .update_i     (win_update),
    .pass_i       (~fail_q),
    .last_i       (tap_q == TW1'(MAX_TAP)),
    .tap_i        (tap_q),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  assign center_tap = best_start + ((best_len - TW1'(1)) >> 1);

  // Training FSM next-state, tap-load and lane result logic.
  always_comb begin
    state_d         = state_q;
    lane_d          = lane_q;
    tap_d           = tap_q;
    cnt_d           = cnt_q;
    fail_d          = fail_q;
    lane_ok_d       = lane_ok_q;
    dly_cnt_value_d = dly_cnt_value_q;
    dly_load_d      = '0;
    win_clear       = 1'b0;
    win_update      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          state_d   = S_LOAD;
          lane_d    = '0;
          tap_d     = '0;
          cnt_d     = '0;
          fail_d    = 1'b0;
          lane_ok_d = '0;
          win_clear = 1'b1;
        end
      end

      S_LOAD: begin
        dly_cnt_value_d[lane_q*TAP_W +: TAP_W] = TAP_W'(tap_q);
        dly_load_d[lane_q] = 1'b1;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end

      S_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          fail_d  = 1'b0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if ((q1_q[lane_q] != TRAIN_Q1) || (q2_q[lane_q] != TRAIN_Q2)) begin
          fail_d  = 1'b1;
          state_d = S_UPDATE;
        end else if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_UPDATE: begin
        win_update = 1'b1;
        if (tap_q < TW1'(MAX_TAP)) begin
          tap_d   = tap_q + TW1'(1);
          state_d = S_LOAD;
        end else begin
          state_d = S_CENTER;
        end
      end

      S_CENTER: begin
        if (best_len >= TW1'(MIN_EYE)) begin
          dly_cnt_value_d[lane_q*TAP_W +: TAP_W] = TAP_W'(center_tap);
          lane_ok_d[lane_q] = 1'b1;
        end else begin
          dly_cnt_value_d[lane_q*TAP_W +: TAP_W] = TAP_W'(DEFAULT_TAP);
        end
        dly_load_d[lane_q] = 1'b1;
        if (lane_q < LANE_W'(WIDTH - 1)) begin
          lane_d    = lane_q + LANE_W'(1);
          tap_d     = '0;
          win_clear = 1'b1;
          state_d   = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Training FSM and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      lane_q          <= '0;
      tap_q           <= '0;
      cnt_q           <= '0;
      fail_q          <= 1'b0;
      lane_ok_q       <= '0;
      dly_cnt_value_q <= '0;
      dly_load_q      <= '0;
    end else begin
      state_q         <= state_d;
      lane_q          <= lane_d;
      tap_q           <= tap_d;
      cnt_q           <= cnt_d;
      fail_q          <= fail_d;
      lane_ok_q       <= lane_ok_d;
      dly_cnt_value_q <= dly_cnt_value_d;
      dly_load_q      <= dly_load_d;
    end
  end

  assign q1            = q1_q;
  assign q2            = q2_q;
  assign cal_busy      = (state_q != S_IDLE);
  assign cal_done      = (state_q == S_DONE);
  assign lane_ok       = lane_ok_q;
  assign dly_cnt_value = dly_cnt_value_q;
  assign dly_load      = dly_load_q;

endmodule

// File: tb/tb_iddr_cal.sv
// Testbench for iddr_cal: models the external delay cells so each lane's data
// is the training pattern (1 at posedge, 0 at negedge) only while its loaded
// tap lies inside a configurable window, and the inverted pattern otherwise.
`timescale 1ns/1ps
module tb_iddr_cal;

  localparam int WIDTH   = 2;
  localparam int TAP_W   = 9;
  localparam int MAX_TAP = 63;
  localparam int DEF_TAP = 7;
  localparam int LOADS_PER_LANE = MAX_TAP + 2;  // every swept tap plus the final load

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [WIDTH-1:0]       d;
  logic [WIDTH-1:0]       q1, q2, lane_ok, dly_load;
  logic                   cal_start = 1'b0;
  logic                   cal_busy, cal_done;
  logic [WIDTH*TAP_W-1:0] dly_cnt_value;

  int passed = 0;
  int total  = 0;

  iddr_cal #(
    .WIDTH         (WIDTH),
    .TAP_W         (TAP_W),
    .MAX_TAP       (MAX_TAP),
    .SETTLE_CYCLES (8),
    .SAMPLE_CYCLES (16),
    .MIN_EYE       (4),
    .DEFAULT_TAP   (DEF_TAP),
    .TRAIN_Q1      (1'b1),
    .TRAIN_Q2      (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .d             (d),
    .q1            (q1),
    .q2            (q2),
    .cal_start     (cal_start),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done),
    .lane_ok       (lane_ok),
    .dly_cnt_value (dly_cnt_value),
    .dly_load      (dly_load)
  );

  always #5 clk = ~clk;

  // Training pattern, shifted 3 ns off the clock edges: 1 at every posedge, 0 at every negedge.
  logic phase = 1'b0;
  always @(posedge clk) begin #3 phase = 1'b0; end
  always @(negedge clk) begin #3 phase = 1'b1; end

  // Delay-cell model
  int win_lo0 [WIDTH] = '{1, 1};
  int win_hi0 [WIDTH] = '{0, 0};
  int win_lo1 [WIDTH] = '{1, 1};
  int win_hi1 [WIDTH] = '{0, 0};
  int model_tap [WIDTH] = '{0, 0};
  logic             manual = 1'b0;
  logic [WIDTH-1:0] d_man  = '0;
  logic [WIDTH-1:0]       ld_s;
  logic [WIDTH*TAP_W-1:0] val_s;

  always_comb begin
    d = '0;
    for (int n = 0; n < WIDTH; n++) begin
      if (manual)
        d[n] = d_man[n];
      else if ((model_tap[n] >= win_lo0[n] && model_tap[n] <= win_hi0[n]) ||
               (model_tap[n] >= win_lo1[n] && model_tap[n] <= win_hi1[n]))
        d[n] = phase;
      else
        d[n] = ~phase;
    end
  end

  // Delay cells latch the tap on a load strobe; applied just after the edge.
  always @(posedge clk) begin
    ld_s  = dly_load;
    val_s = dly_cnt_value;
    #1;
    for (int n = 0; n < WIDTH; n++)
      if (ld_s[n]) model_tap[n] = int'(val_s[n*TAP_W +: TAP_W]);
  end

  // Activity monitor, sampled mid-cycle.
  int cyc = 0, load_cnt0 = 0, load_cnt1 = 0, multi_load = 0, done_cnt = 0;
  int last_l0 = 0, first_l1 = 0;
  always @(negedge clk) begin
    cyc++;
    if (dly_load[0]) begin load_cnt0++; last_l0 = cyc; end
    if (dly_load[1]) begin load_cnt1++; if (first_l1 == 0) first_l1 = cyc; end
    if ($countones(dly_load) > 1) multi_load++;
    if (cal_done) done_cnt++;
  end

  task automatic set_win(input int lane, input int lo0, input int hi0, input int lo1, input int hi1);
    win_lo0[lane] = lo0; win_hi0[lane] = hi0;
    win_lo1[lane] = lo1; win_hi1[lane] = hi1;
  endtask

  // Pulses cal_start and waits (bounded) for cal_done; optionally pulses cal_start again mid-run.
  task automatic run_cal(input int again_at, output bit timed_out);
    load_cnt0 = 0; load_cnt1 = 0; multi_load = 0; done_cnt = 0;
    last_l0 = 0; first_l1 = 0;
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      cal_start = (i == again_at);
      if (cal_done) begin timed_out = 1'b0; break; end
    end
    cal_start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (q1 !== '0) $display("FAIL reset_q1: got %b want 00", q1); else passed++;
    total++; if (q2 !== '0) $display("FAIL reset_q2: got %b want 00", q2); else passed++;
    total++; if (cal_busy !== 1'b0 || cal_done !== 1'b0) $display("FAIL reset_busy_done: got %b%b want 00", cal_busy, cal_done); else passed++;
    total++; if (lane_ok !== '0 || dly_load !== '0) $display("FAIL reset_ok_load: got %b %b want 00 00", lane_ok, dly_load); else passed++;
    total++; if (dly_cnt_value !== '0) $display("FAIL reset_dly_cnt: got %h want 0", dly_cnt_value); else passed++;
    rst = 1'b0;
    load_cnt0 = 0; load_cnt1 = 0;
    repeat (20) @(negedge clk);
    total++; if (load_cnt0 + load_cnt1 != 0 || cal_busy !== 1'b0) $display("FAIL reset_exit_quiet: got loads=%0d busy=%b want 0 0", load_cnt0 + load_cnt1, cal_busy); else passed++;
  endtask

  task automatic test_capture;
    manual = 1'b1; d_man = '0;
    repeat (3) @(posedge clk);
    #2 d_man = '0;                       // negedge sample before P0
    @(negedge clk); #2 d_man = '1;       // rising sample at P0
    @(posedge clk); #1;
    total++; if (q1 !== 2'b00 || q2 !== 2'b00) $display("FAIL capture_before: got q1=%b q2=%b want 00 00", q1, q2); else passed++;
    d_man = '0;                          // falling sample of P0's period
    @(negedge clk); #2 d_man = '0;       // rising sample at P1
    @(posedge clk); #1;
    total++; if (q1 !== 2'b11 || q2 !== 2'b00) $display("FAIL capture_rise1_fall0: got q1=%b q2=%b want 11 00", q1, q2); else passed++;
    d_man = '1;                          // falling sample of P1's period
    @(negedge clk); #2 d_man = '0;
    @(posedge clk); #1;
    total++; if (q1 !== 2'b00 || q2 !== 2'b11) $display("FAIL capture_rise0_fall1: got q1=%b q2=%b want 00 11", q1, q2); else passed++;
    manual = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_eye;
    bit to;
    set_win(0, 10, 30, 1, 0); set_win(1, 1, 0, 1, 0);
    run_cal(-1, to);
    total++; if (to) $display("FAIL single_timeout: no cal_done within bound"); else passed++;
    total++; if (model_tap[0] != 20) $display("FAIL single_tap0: got %0d want 20", model_tap[0]); else passed++;
    total++; if (model_tap[1] != DEF_TAP) $display("FAIL single_tap1_default: got %0d want %0d", model_tap[1], DEF_TAP); else passed++;
    total++; if (lane_ok !== 2'b01) $display("FAIL single_lane_ok: got %b want 01", lane_ok); else passed++;
    total++; if (done_cnt != 1) $display("FAIL single_done_pulses: got %0d want 1", done_cnt); else passed++;
    total++; if (load_cnt0 != LOADS_PER_LANE) $display("FAIL single_loads: got %0d want %0d", load_cnt0, LOADS_PER_LANE); else passed++;
    total++; if (cal_busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", cal_busy); else passed++;
  endtask

  task automatic test_two_eyes;
    bit to;
    set_win(0, 5, 8, 40, 47);
    run_cal(-1, to);
    total++; if (to || model_tap[0] != 43) $display("FAIL two_eyes_tap: got %0d timeout=%0b want 43", model_tap[0], to); else passed++;
    set_win(0, 5, 8, 20, 23);
    run_cal(-1, to);
    total++; if (to || model_tap[0] != 6) $display("FAIL tie_first_wins: got %0d timeout=%0b want 6", model_tap[0], to); else passed++;
    total++; if (lane_ok !== 2'b01) $display("FAIL tie_lane_ok: got %b want 01", lane_ok); else passed++;
  endtask

  task automatic test_max_edge;
    bit to;
    set_win(0, 50, 63, 1, 0);
    run_cal(-1, to);
    total++; if (to || model_tap[0] != 56) $display("FAIL max_edge_tap: got %0d timeout=%0b want 56", model_tap[0], to); else passed++;
    total++; if (lane_ok !== 2'b01) $display("FAIL max_edge_lane_ok: got %b want 01", lane_ok); else passed++;
  endtask

  task automatic test_narrow_eye;
    bit to;
    set_win(0, 20, 22, 1, 0);
    run_cal(-1, to);
    total++; if (to || model_tap[0] != DEF_TAP) $display("FAIL narrow_tap: got %0d timeout=%0b want %0d", model_tap[0], to, DEF_TAP); else passed++;
    total++; if (lane_ok !== 2'b00) $display("FAIL narrow_lane_ok: got %b want 00", lane_ok); else passed++;
  endtask

  task automatic test_two_lanes;
    bit to;
    set_win(0, 10, 20, 1, 0); set_win(1, 30, 40, 1, 0);
    run_cal(-1, to);
    total++; if (to) $display("FAIL lanes_timeout: no cal_done within bound"); else passed++;
    total++; if (model_tap[0] != 15 || model_tap[1] != 35) $display("FAIL lanes_taps: got %0d %0d want 15 35", model_tap[0], model_tap[1]); else passed++;
    total++; if (lane_ok !== 2'b11) $display("FAIL lanes_lane_ok: got %b want 11", lane_ok); else passed++;
    total++; if (load_cnt0 != LOADS_PER_LANE || load_cnt1 != LOADS_PER_LANE) $display("FAIL lanes_loads: got %0d %0d want %0d each", load_cnt0, load_cnt1, LOADS_PER_LANE); else passed++;
    total++; if (!(last_l0 < first_l1)) $display("FAIL lanes_order: got last lane0 load cyc %0d, first lane1 cyc %0d, want lane0 first", last_l0, first_l1); else passed++;
    total++; if (multi_load != 0) $display("FAIL lanes_onehot_load: got %0d multi-bit cycles want 0", multi_load); else passed++;
  endtask

  task automatic test_busy_ignore;
    bit to;
    set_win(0, 10, 30, 1, 0); set_win(1, 1, 0, 1, 0);
    run_cal(300, to);
    total++; if (to || done_cnt != 1) $display("FAIL busy_done_pulses: got %0d timeout=%0b want 1", done_cnt, to); else passed++;
    total++; if (load_cnt0 != LOADS_PER_LANE || load_cnt1 != LOADS_PER_LANE) $display("FAIL busy_loads: got %0d %0d want %0d each", load_cnt0, load_cnt1, LOADS_PER_LANE); else passed++;
    total++; if (model_tap[0] != 20) $display("FAIL busy_tap: got %0d want 20", model_tap[0]); else passed++;
  endtask

  task automatic test_reset_mid;
    set_win(0, 0, 30, 1, 0);
    @(negedge clk); cal_start = 1'b1;
    @(negedge clk); cal_start = 1'b0;
    repeat (15) @(negedge clk);          // inside CHECK of tap 0 (passing, 16 cycles)
    total++; if (cal_busy !== 1'b1 || q1[0] !== 1'b1) $display("FAIL mid_pre_busy: got busy=%b q1=%b want 1 x1", cal_busy, q1); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (cal_busy !== 1'b0 || cal_done !== 1'b0 || q1 !== '0 || q2 !== '0) $display("FAIL mid_reset_flags: got busy=%b done=%b q1=%b q2=%b want 0 0 00 00", cal_busy, cal_done, q1, q2); else passed++;
    total++; if (dly_cnt_value !== '0 || dly_load !== '0 || lane_ok !== '0) $display("FAIL mid_reset_dly: got %h %b %b want 0 00 00", dly_cnt_value, dly_load, lane_ok); else passed++;
    @(negedge clk); rst = 1'b0;
    load_cnt0 = 0; load_cnt1 = 0; done_cnt = 0;
    repeat (30) @(negedge clk);
    total++; if (load_cnt0 + load_cnt1 != 0 || cal_busy !== 1'b0 || done_cnt != 0) $display("FAIL mid_release_quiet: got loads=%0d busy=%b done=%0d want 0 0 0", load_cnt0 + load_cnt1, cal_busy, done_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_capture;
    test_single_eye;
    test_two_eyes;
    test_max_edge;
    test_narrow_eye;
    test_two_lanes;
    test_busy_ignore;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
